// File: rtl/bullet_fire_scheduler.sv
// Shares a pool of bullet datapath slots between two players: press-edge capture, cooldown,
// live-bullet caps and round-robin arbitration. Define BULLET_AMMO_EN for magazine/reload.
module bullet_fire_scheduler #(
    parameter int unsigned N_SLOTS         = 4,
    parameter int unsigned MAX_PER_PLAYER  = 2,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned AMMO_INIT       = 6
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [1:0]                 fire_req,
    input  logic [1:0]                 dir_p1,
    input  logic [1:0]                 dir_p2,
    input  logic [9:0]                 p1_x,
    input  logic [9:0]                 p1_y,
    input  logic [9:0]                 p2_x,
    input  logic [9:0]                 p2_y,
    input  logic [9:0]                 p_size,
    input  logic [N_SLOTS-1:0]         slot_done,
    input  logic [1:0]                 reload,
    output logic                       launch_valid,
    output logic [$clog2(N_SLOTS)-1:0] launch_slot,
    output logic                       launch_owner,
    output logic [1:0]                 launch_dir,
    output logic [9:0]                 launch_x,
    output logic [9:0]                 launch_y,
    output logic [N_SLOTS-1:0]         slot_busy,
    output logic [N_SLOTS-1:0]         slot_owner,
    output logic [7:0]                 ammo_p1,
    output logic [7:0]                 ammo_p2
);
    localparam int unsigned SlotW    = $clog2(N_SLOTS);
    localparam logic [3:0]  MaxCnt   = 4'(MAX_PER_PLAYER);
    localparam logic [7:0]  CoolLoad = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0]  AmmoInit = 8'(AMMO_INIT);

    typedef enum logic [1:0] {StArmed, StPending, StCooldown} player_st_e;

    player_st_e         state_q [2];
    player_st_e         state_d [2];
    logic [7:0]         cool_q  [2];
    logic [7:0]         cool_d  [2];
    logic [3:0]         cnt     [2];
    logic [1:0]         fire_prev_q;
    logic [1:0]         press;
    logic [1:0]         pending;
    logic [1:0]         ammo_ok;
    logic [1:0]         eligible;
    logic               rr_last_q;
    logic               grant;
    logic               gnt_owner;
    logic               any_free;
    logic [SlotW-1:0]   free_idx;
    logic [N_SLOTS-1:0] busy_q;
    logic [N_SLOTS-1:0] busy_d;
    logic [N_SLOTS-1:0] owner_q;
    logic [N_SLOTS-1:0] owner_d;
    logic [1:0]         spawn_dir;
    logic [9:0]         spawn_x;
    logic [9:0]         spawn_y;

    assign press = fire_req & ~fire_prev_q;

    // Player FSM: state register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= StArmed;
                cool_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                cool_q[p]  <= cool_d[p];
            end
        end
    end

    // Player FSM: next state. The player stays in cooldown for COOLDOWN_FRAMES frames.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            cool_d[p]  = cool_q[p];
            case (state_q[p])
                StArmed: begin
                    if (press[p]) state_d[p] = StPending;
                end
                StPending: begin
                    if (grant && (gnt_owner == 1'(p))) begin
                        state_d[p] = StCooldown;
                        cool_d[p]  = CoolLoad;
                    end
                end
                StCooldown: begin
                    if (cool_q[p] == 8'd0) state_d[p] = StArmed;
                    else                   cool_d[p]  = cool_q[p] - 8'd1;
                end
                default: state_d[p] = StArmed;
            endcase
        end
    end

    // Player FSM: outputs
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pending[p] = (state_q[p] == StPending);
        end
    end

    // Live counts are derived from the slot table, so they can never wrap or drift.
    always_comb begin
        cnt[0]   = '0;
        cnt[1]   = '0;
        free_idx = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!busy_q[s]) free_idx = SlotW'(s);
            if (busy_q[s])  cnt[owner_q[s]] = cnt[owner_q[s]] + 4'd1;
        end
    end

    assign any_free = ~&busy_q;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            eligible[p] = pending[p] & any_free & (cnt[p] < MaxCnt) & ammo_ok[p];
        end
    end

    assign grant     = |eligible;
    assign gnt_owner = (&eligible) ? ~rr_last_q : eligible[1];

    always_comb begin
        busy_d  = busy_q & ~slot_done;
        owner_d = owner_q;
        if (grant) begin
            busy_d[free_idx]  = 1'b1;
            owner_d[free_idx] = gnt_owner;
        end
    end

    assign spawn_dir = gnt_owner ? dir_p2 : dir_p1;
    assign spawn_x   = (gnt_owner ? p2_x : p1_x) + p_size;
    assign spawn_y   = (gnt_owner ? p2_y : p1_y) + p_size;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_prev_q  <= 2'b11;
            rr_last_q    <= 1'b1;
            busy_q       <= '0;
            owner_q      <= '0;
            launch_valid <= 1'b0;
            launch_slot  <= '0;
            launch_owner <= 1'b0;
            launch_dir   <= '0;
            launch_x     <= '0;
            launch_y     <= '0;
        end else begin
            fire_prev_q  <= fire_req;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            launch_valid <= grant;
            if (grant) begin
                rr_last_q    <= gnt_owner;
                launch_slot  <= free_idx;
                launch_owner <= gnt_owner;
                launch_dir   <= spawn_dir;
                launch_x     <= spawn_x;
                launch_y     <= spawn_y;
            end
        end
    end

    assign slot_busy  = busy_q;
    assign slot_owner = owner_q;

`ifdef BULLET_AMMO_EN
    logic [7:0] ammo_q [2];

    // Reload takes priority over a same-frame grant.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < 2; p++) ammo_q[p] <= AmmoInit;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (reload[p])                              ammo_q[p] <= AmmoInit;
                else if (grant && (gnt_owner == 1'(p)))     ammo_q[p] <= ammo_q[p] - 8'd1;
            end
        end
    end

    assign ammo_ok[0] = (ammo_q[0] != 8'd0);
    assign ammo_ok[1] = (ammo_q[1] != 8'd0);
    assign ammo_p1    = ammo_q[0];
    assign ammo_p2    = ammo_q[1];
`else
    logic unused_reload;

    assign unused_reload = ^reload;
    assign ammo_ok       = 2'b11;
    assign ammo_p1       = AmmoInit;
    assign ammo_p2       = AmmoInit;
`endif

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// Directed bench for bullet_fire_scheduler (default parameters: 4 slots, cap 2, cooldown 8).
module tb_bullet_fire_scheduler;
    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [1:0] fire_req;
    logic [1:0] dir_p1;
    logic [1:0] dir_p2;
    logic [9:0] p1_x;
    logic [9:0] p1_y;
    logic [9:0] p2_x;
    logic [9:0] p2_y;
    logic [9:0] p_size;
    logic [3:0] slot_done;
    logic [1:0] reload;
    logic       launch_valid;
    logic [1:0] launch_slot;
    logic       launch_owner;
    logic [1:0] launch_dir;
    logic [9:0] launch_x;
    logic [9:0] launch_y;
    logic [3:0] slot_busy;
    logic [3:0] slot_owner;
    logic [7:0] ammo_p1;
    logic [7:0] ammo_p2;

    int n_vec = 0;
    int n_err = 0;

    bullet_fire_scheduler dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire_req     (fire_req),
        .dir_p1       (dir_p1),
        .dir_p2       (dir_p2),
        .p1_x         (p1_x),
        .p1_y         (p1_y),
        .p2_x         (p2_x),
        .p2_y         (p2_y),
        .p_size       (p_size),
        .slot_done    (slot_done),
        .reload       (reload),
        .launch_valid (launch_valid),
        .launch_slot  (launch_slot),
        .launch_owner (launch_owner),
        .launch_dir   (launch_dir),
        .launch_x     (launch_x),
        .launch_y     (launch_y),
        .slot_busy    (slot_busy),
        .slot_owner   (slot_owner),
        .ammo_p1      (ammo_p1),
        .ammo_p2      (ammo_p2)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; fire_req = 2'b00; slot_done = '0; reload = 2'b00;
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; fire_req = 2'b01; slot_done = '0; reload = 2'b00;
        dir_p1 = 2'b01; dir_p2 = 2'b00;
        p1_x = 10'd100; p1_y = 10'd200; p2_x = 10'd500; p2_y = 10'd300; p_size = 10'd16;
        step(); step();
        n_vec++; if (launch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", launch_valid); end
        n_vec++; if (slot_busy !== 4'b0000) begin n_err++; $display("FAIL rst_busy got %b want 0000", slot_busy); end
        n_vec++; if (slot_owner !== 4'b0000) begin n_err++; $display("FAIL rst_owner got %b want 0000", slot_owner); end
        n_vec++; if (launch_x !== 10'd0) begin n_err++; $display("FAIL rst_x got %0d want 0", launch_x); end
        n_vec++; if (ammo_p1 !== 8'd6 || ammo_p2 !== 8'd6) begin
            n_err++; $display("FAIL rst_ammo got %0d/%0d want 6/6", ammo_p1, ammo_p2);
        end
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (launch_valid !== 1'b0 || slot_busy !== 4'b0000) begin
                n_err++; $display("FAIL held_through_reset frame %0d got v=%b busy=%b want 0/0000", i, launch_valid, slot_busy);
            end
        end
        fire_req = 2'b00; step();
        fire_req = 2'b01; step();
        n_vec++; if (launch_valid !== 1'b0) begin n_err++; $display("FAIL edge_frame_valid got %b want 0", launch_valid); end
        step();
        n_vec++; if (launch_valid !== 1'b1) begin n_err++; $display("FAIL first_launch_valid got %b want 1", launch_valid); end
        n_vec++; if ({launch_slot, launch_owner, launch_dir} !== {2'd0, 1'b0, 2'b01}) begin
            n_err++; $display("FAIL first_launch_cmd got slot=%0d own=%0d dir=%b want 0/0/01", launch_slot, launch_owner, launch_dir);
        end
        n_vec++; if (launch_x !== 10'd116 || launch_y !== 10'd216) begin
            n_err++; $display("FAIL first_launch_pos got %0d,%0d want 116,216", launch_x, launch_y);
        end
        n_vec++; if (slot_busy !== 4'b0001) begin n_err++; $display("FAIL first_busy got %b want 0001", slot_busy); end
        fire_req = 2'b00; step();
        n_vec++; if (launch_valid !== 1'b0 || launch_x !== 10'd116) begin
            n_err++; $display("FAIL launch_hold got v=%b x=%0d want 0/116", launch_valid, launch_x);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fire_req = 2'b11; step();
        n_vec++; if (launch_valid !== 1'b0) begin n_err++; $display("FAIL rr_edge_valid got %b want 0", launch_valid); end
        fire_req = 2'b00; step();
        n_vec++; if ({launch_valid, launch_slot, launch_owner} !== {1'b1, 2'd0, 1'b0}) begin
            n_err++; $display("FAIL rr_first got v=%b slot=%0d own=%0d want 1/0/0", launch_valid, launch_slot, launch_owner);
        end
        step();
        n_vec++; if ({launch_valid, launch_slot, launch_owner, launch_dir} !== {1'b1, 2'd1, 1'b1, 2'b00}) begin
            n_err++; $display("FAIL rr_second got v=%b slot=%0d own=%0d dir=%b want 1/1/1/00",
                              launch_valid, launch_slot, launch_owner, launch_dir);
        end
        n_vec++; if (launch_x !== 10'd516 || launch_y !== 10'd316) begin
            n_err++; $display("FAIL rr_p2_pos got %0d,%0d want 516,316", launch_x, launch_y);
        end
        n_vec++; if (slot_busy !== 4'b0011 || slot_owner !== 4'b0010) begin
            n_err++; $display("FAIL rr_slots got busy=%b own=%b want 0011/0010", slot_busy, slot_owner);
        end
        step();
        n_vec++; if (launch_valid !== 1'b0) begin n_err++; $display("FAIL rr_after got %b want 0", launch_valid); end
    endtask

    // P1 presses every other frame; cooldown discards presses, cap of 2 holds the third.
    task automatic test_cooldown_cap();
        logic exp_v;
        logic [1:0] exp_s;
        do_reset();
        for (int k = 0; k <= 27; k++) begin
            fire_req  = {1'b0, (k % 2) == 0};
            slot_done = (k == 26) ? 4'b0001 : 4'b0000;
            step();
            exp_v = (k == 1) || (k == 11) || (k == 27);
            exp_s = (k == 11) ? 2'd1 : 2'd0;
            n_vec++; if (launch_valid !== exp_v) begin
                n_err++; $display("FAIL cool_valid frame %0d got %b want %b", k, launch_valid, exp_v);
            end
            if (exp_v) begin
                n_vec++; if (launch_slot !== exp_s || launch_owner !== 1'b0) begin
                    n_err++; $display("FAIL cool_slot frame %0d got %0d/%0d want %0d/0", k, launch_slot, launch_owner, exp_s);
                end
            end
            if (k == 24) begin
                n_vec++; if (slot_busy !== 4'b0011) begin n_err++; $display("FAIL cap_busy got %b want 0011", slot_busy); end
            end
        end
        fire_req = 2'b00; slot_done = '0;
    endtask

    task automatic test_pool_full();
        logic exp_v;
        logic [1:0] exp_s;
        logic exp_o;
        do_reset();
        for (int k = 0; k <= 26; k++) begin
            fire_req = 2'b00; slot_done = '0;
            case (k)
                0:  fire_req  = 2'b11;
                11: fire_req  = 2'b10;
                12: fire_req  = 2'b01;
                21: fire_req  = 2'b10;
                25: slot_done = 4'b0100;
                default: ;
            endcase
            step();
            exp_v = (k == 1) || (k == 2) || (k == 12) || (k == 13) || (k == 26);
            case (k)
                1:  begin exp_s = 2'd0; exp_o = 1'b0; end
                2:  begin exp_s = 2'd1; exp_o = 1'b1; end
                13: begin exp_s = 2'd3; exp_o = 1'b0; end
                default: begin exp_s = 2'd2; exp_o = 1'b1; end
            endcase
            n_vec++; if (launch_valid !== exp_v) begin
                n_err++; $display("FAIL pool_valid frame %0d got %b want %b", k, launch_valid, exp_v);
            end
            if (exp_v) begin
                n_vec++; if (launch_slot !== exp_s || launch_owner !== exp_o) begin
                    n_err++; $display("FAIL pool_cmd frame %0d got %0d/%0d want %0d/%0d", k, launch_slot, launch_owner, exp_s, exp_o);
                end
            end
            if (k == 13 || k == 26) begin
                n_vec++; if (slot_busy !== 4'b1111 || slot_owner !== 4'b0110) begin
                    n_err++; $display("FAIL pool_full frame %0d got busy=%b own=%b want 1111/0110", k, slot_busy, slot_owner);
                end
            end
            if (k == 25) begin
                n_vec++; if (slot_busy !== 4'b1011) begin n_err++; $display("FAIL pool_freed got %b want 1011", slot_busy); end
            end
        end
    endtask

    // Runs on the full pool left by test_pool_full.
    task automatic test_idle_done_and_reset();
        slot_done = 4'b0001; step();
        slot_done = 4'b0001; step();
        n_vec++; if (slot_busy !== 4'b1110 || slot_owner !== 4'b0110) begin
            n_err++; $display("FAIL idle_done got busy=%b own=%b want 1110/0110", slot_busy, slot_owner);
        end
        slot_done = '0;
        fire_req = 2'b01; step();
        fire_req = 2'b00; step();
        n_vec++; if ({launch_valid, launch_slot, launch_owner} !== {1'b1, 2'd0, 1'b0}) begin
            n_err++; $display("FAIL idle_count got v=%b slot=%0d own=%0d want 1/0/0", launch_valid, launch_slot, launch_owner);
        end
        slot_done = 4'b0001; step();
        slot_done = '0;
        n_vec++; if (slot_busy !== 4'b1110) begin n_err++; $display("FAIL three_busy got %b want 1110", slot_busy); end
        Reset = 1'b1; #2;
        n_vec++; if (slot_busy !== 4'b0000 || slot_owner !== 4'b0000) begin
            n_err++; $display("FAIL async_rst_slots got busy=%b own=%b want 0000/0000", slot_busy, slot_owner);
        end
        n_vec++; if ({launch_valid, launch_slot, launch_owner, launch_x} !== 14'd0) begin
            n_err++; $display("FAIL async_rst_cmd got v=%b slot=%0d own=%0d x=%0d want zeros",
                              launch_valid, launch_slot, launch_owner, launch_x);
        end
        step();
        Reset = 1'b0; step();
        fire_req = 2'b10; step();
        fire_req = 2'b00; step();
        n_vec++; if ({launch_valid, launch_slot, launch_owner} !== {1'b1, 2'd0, 1'b1}) begin
            n_err++; $display("FAIL post_rst_launch got v=%b slot=%0d own=%0d want 1/0/1", launch_valid, launch_slot, launch_owner);
        end
    endtask

`ifdef BULLET_AMMO_EN
    task automatic test_ammo();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fire_req = 2'b01; step();
            fire_req = 2'b00; step();
            n_vec++; if (launch_valid !== 1'b1 || ammo_p1 !== 8'(5 - i)) begin
                n_err++; $display("FAIL ammo_shot %0d got v=%b ammo=%0d want 1/%0d", i, launch_valid, ammo_p1, 5 - i);
            end
            slot_done = 4'b0001; step();
            slot_done = '0;
            for (int j = 0; j < 7; j++) step();
        end
        fire_req = 2'b01; step();
        fire_req = 2'b00; step(); step();
        n_vec++; if (launch_valid !== 1'b0 || ammo_p1 !== 8'd0) begin
            n_err++; $display("FAIL ammo_empty got v=%b ammo=%0d want 0/0", launch_valid, ammo_p1);
        end
        reload = 2'b01; step();
        reload = 2'b00;
        n_vec++; if (ammo_p1 !== 8'd6) begin n_err++; $display("FAIL ammo_reload got %0d want 6", ammo_p1); end
        step();
        n_vec++; if (launch_valid !== 1'b1 || ammo_p1 !== 8'd5) begin
            n_err++; $display("FAIL ammo_after_reload got v=%b ammo=%0d want 1/5", launch_valid, ammo_p1);
        end
    endtask
`else
    task automatic test_ammo();
        reload = 2'b11; step();
        reload = 2'b00; step();
        n_vec++; if (ammo_p1 !== 8'd6 || ammo_p2 !== 8'd6) begin
            n_err++; $display("FAIL ammo_tied got %0d/%0d want 6/6", ammo_p1, ammo_p2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_cooldown_cap();
        test_pool_full();
        test_idle_done_and_reset();
        test_ammo();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
